// File: rtl/raysketch_pkg.sv
// Shared types, defaults and helpers for the ray-sketch pixel output path.
package raysketch_pkg;

  localparam int unsigned CLK_HZ_DEFAULT = 100_000_000;
  localparam int unsigned BAUD_DEFAULT   = 115_200;

  // One pixel colour, most significant byte sent first.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  // Clock cycles per UART bit, integer-truncated.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Byte of a pixel by transmit index: 0 = R, 1 = G, 2 = B.
  function automatic logic [7:0] rgb_byte(input rgb_t pix, input logic [1:0] idx);
    case (idx)
      2'd0:    return pix.r;
      2'd1:    return pix.g;
      default: return pix.b;
    endcase
  endfunction

endpackage

// File: rtl/rgb_uart_framer_if.sv
// Pixel push handshake, status flags and UART line of the framer.
interface rgb_uart_framer_if;
  import raysketch_pkg::*;

  logic start;
  rgb_t rgb;
  logic busy;
  logic idle;
  logic overflow;
  logic TxD;

  modport master (output start, output rgb,
                  input busy, input idle, input overflow, input TxD);
  modport slave  (input start, input rgb,
                  output busy, output idle, output overflow, output TxD);
endinterface

// File: rtl/pixel_fifo.sv
// Small pointer-wrap FIFO; full/empty decoded from registered pointers.
module pixel_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                        wr_en, rd_en;

  assign full_c    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_c   = (wr_q == rd_q);
  assign rd_data_c = mem_q[rd_q[AW-1:0]];
  assign wr_en     = push & ~full_c;
  assign rd_en     = pop & ~empty_c;

  // Next pointers and storage.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_q[AW-1:0]] = wr_data;
      wr_d                = wr_q + PW'(1);
    end
    if (rd_en) begin
      rd_d = rd_q + PW'(1);
    end
  end

  // Pointer and storage registers; reset discards queued entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/rgb_uart_framer.sv
// Queues 24-bit pixels and sends each as three 8N1 UART bytes (R, G, B).
module rgb_uart_framer
  import raysketch_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEFAULT,
  parameter int unsigned BAUD       = BAUD_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  rgb_uart_framer_if.slave bus
);

  localparam int unsigned CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned RGB_W = $bits(rgb_t);

  tx_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  rgb_t               shadow_q, shadow_d;
  logic               txd_q, txd_d;
  logic               overflow_q, overflow_d;

  logic               fifo_full, fifo_empty, fifo_pop, push;
  logic [RGB_W-1:0]   fifo_rd_data;
  logic               bit_end;
  logic [7:0]         cur_byte;

  // A push is judged only against the registered full flag.
  assign push     = bus.start & ~fifo_full;
  assign fifo_pop = (state_q == ST_LOAD);
  assign bit_end  = (cnt_q == CNT_W'(CPB - 1));

  pixel_fifo #(
    .WIDTH (RGB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (push),
    .wr_data   (RGB_W'(bus.rgb)),
    .pop       (fifo_pop),
    .rd_data_c (fifo_rd_data),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty)
  );

  // Serializer next state, baud/bit/byte counters and next line level.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    shadow_d   = shadow_q;
    overflow_d = overflow_q | (bus.start & fifo_full);

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        shadow_d = rgb_t'(fifo_rd_data);
        byte_d   = 2'd0;
        bit_d    = 3'd0;
        cnt_d    = '0;
        state_d  = ST_START;
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (byte_q < 2'd2) begin
            byte_d  = byte_q + 2'd1;
            state_d = ST_START;
          end else if (!fifo_empty) begin
            state_d = ST_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Line level follows the state being entered so TxD stays registered.
    cur_byte = rgb_byte(shadow_d, byte_d);
    case (state_d)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = cur_byte[bit_d];
      default:  txd_d = 1'b1;
    endcase
  end

  // Serializer registers; reset forces the line high mid-frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      shadow_q   <= '0;
      txd_q      <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      shadow_q   <= shadow_d;
      txd_q      <= txd_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = fifo_full;
  assign bus.idle     = fifo_empty & (state_q == ST_IDLE);
  assign bus.overflow = overflow_q;
  assign bus.TxD      = txd_q;

endmodule

// File: tb/tb_rgb_uart_framer.sv
// Bench for rgb_uart_framer: UART line receiver plus pixel-list reference model.
module tb_rgb_uart_framer;
  import raysketch_pkg::*;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DEPTH  = 4;
  localparam int CPB    = 10;          // 1 MHz / 100 kBd
  localparam int BYTE_T = 10 * CPB;
  localparam int PIX_T  = 30 * CPB;
  localparam int IDLE_LIMIT = 4000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  rgb_uart_framer_if bus();

  rgb_uart_framer #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART receiver: every cycle of each frame must hold the right level.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         rx_err = 0;
  bit         rx_act = 0;
  int         rx_s = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    int p;
    int k;
    if (!reset_n) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (bus.TxD === 1'b0) begin
        rx_act = 1;
        rx_s   = cyc;
      end else if (bus.TxD !== 1'b1) begin
        rx_err++;
      end
    end else begin
      p = cyc - rx_s;
      k = p / CPB;
      if (k == 0) begin
        if (bus.TxD !== 1'b0) rx_err++;
      end else if (k <= 8) begin
        if (p % CPB == 0) rx_sh[k-1] = bus.TxD;
        else if (bus.TxD !== rx_sh[k-1]) rx_err++;
      end else begin
        if (bus.TxD !== 1'b1) rx_err++;
        if (p == BYTE_T - 1) begin
          rx_q.push_back(rx_sh);
          rx_t.push_back(rx_s);
          rx_act = 0;
        end
      end
    end
  end

  // Reference model: an accepted pixel becomes bytes R, G, B in order.
  task automatic model_accept(input logic [23:0] p);
    exp_q.push_back(p[23:16]);
    exp_q.push_back(p[15:8]);
    exp_q.push_back(p[7:0]);
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
    rx_err = 0;
  endtask

  task automatic drive(input logic s, input logic [23:0] v, output int edge_n);
    @(negedge clk);
    bus.start = s;
    bus.rgb   = v;
    edge_n    = cyc + 1;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(output int t, output bit ok);
    ok = 0;
    t  = 0;
    for (int i = 0; i < IDLE_LIMIT; i++) begin
      @(negedge clk);
      if (bus.idle === 1'b1 && !rx_act) begin
        t  = cyc;
        ok = 1;
        return;
      end
    end
  endtask

  task automatic do_reset();
    bus.start = 1'b0;
    bus.rgb   = '0;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    clear_rx();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.TxD !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", bus.TxD); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.idle !== 1'b1) begin failures++; $display("FAIL reset_idle got=%b exp=1", bus.idle); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_single_pixel();
    int n, d, t;
    bit ok;
    clear_rx();
    drive(1'b1, 24'hA53C0F, n);
    model_accept(24'hA53C0F);
    drive(1'b0, 24'h0, d);
    checks++; if (bus.idle !== 1'b0) begin failures++; $display("FAIL single_idle_fall got=%b exp=0", bus.idle); end
    wait_idle(t, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=0 exp=1"); end
    checks++; if (t != n + 2 + PIX_T) begin failures++; $display("FAIL single_idle_rise got=%0d exp=%0d", t, n + 2 + PIX_T); end
    checks++; if (rx_err != 0) begin failures++; $display("FAIL single_framing got=%0d exp=0", rx_err); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL single_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    if (rx_t.size() == 3) begin
      checks++; if (rx_t[0] != n + 2) begin failures++; $display("FAIL single_start_latency got=%0d exp=%0d", rx_t[0], n + 2); end
      checks++; if (rx_t[2] - rx_t[0] != 2 * BYTE_T) begin failures++; $display("FAIL single_byte_spacing got=%0d exp=%0d", rx_t[2] - rx_t[0], 2 * BYTE_T); end
    end
  endtask

  task automatic test_back_to_back();
    int n, d, t;
    bit ok;
    clear_rx();
    drive(1'b1, 24'h112233, n);
    drive(1'b1, 24'h445566, d);
    model_accept(24'h112233);
    model_accept(24'h445566);
    drive(1'b0, 24'h0, d);
    wait_idle(t, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=0 exp=1"); end
    checks++; if (rx_err != 0) begin failures++; $display("FAIL b2b_framing got=%0d exp=0", rx_err); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    if (rx_t.size() == 6) begin
      checks++; if (rx_t[3] - (rx_t[2] + 9 * CPB) != CPB + 1) begin
        failures++; $display("FAIL b2b_pixel_gap got=%0d exp=%0d", rx_t[3] - (rx_t[2] + 9 * CPB), CPB + 1);
      end
      checks++; if (rx_t[5] - rx_t[3] != 2 * BYTE_T) begin failures++; $display("FAIL b2b_second_spacing got=%0d exp=%0d", rx_t[5] - rx_t[3], 2 * BYTE_T); end
    end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL b2b_overflow got=%b exp=0", bus.overflow); end
  endtask

  task automatic test_overflow();
    int n, d, t;
    bit ok;
    logic b[7];
    logic [23:0] px;
    clear_rx();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b[i] = bus.busy;
      if (i == 0) n = cyc + 1;
      px = 24'($urandom);
      bus.start = 1'b1;
      bus.rgb   = px;
      if (i < 5) model_accept(px);
    end
    @(negedge clk);
    b[6] = bus.busy;
    bus.start = 1'b0;
    // b[i] reflects the edge before pulse i; occupancy reaches DEPTH after pulse 5.
    for (int i = 0; i < 7; i++) begin
      checks++; if (b[i] !== (i >= 5)) begin failures++; $display("FAIL ovf_busy%0d got=%b exp=%b", i, b[i], (i >= 5)); end
    end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); end
    // Second pop happens one LOAD cycle after the first pixel finishes.
    wait_cyc(n + 2 + PIX_T);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL ovf_busy_before_pop got=%b exp=1", bus.busy); end
    wait_cyc(n + 3 + PIX_T);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ovf_busy_after_pop got=%b exp=0", bus.busy); end
    wait_idle(t, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout got=0 exp=1"); end
    checks++; if (rx_err != 0) begin failures++; $display("FAIL ovf_framing got=%0d exp=0", rx_err); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    d = t;
  endtask

  task automatic test_push_on_pop();
    int n, d, t, p;
    bit ok;
    logic [23:0] px;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      px = 24'($urandom);
      drive(1'b1, px, d);
      if (i == 0) n = d;
      model_accept(px);
    end
    drive(1'b0, 24'h0, d);
    p = n + 3 + PIX_T;
    wait_cyc(p - 1);
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL pop_edge_pre_overflow got=%b exp=0", bus.overflow); end
    bus.start = 1'b1;
    bus.rgb   = 24'hDEAD01;
    px = 24'($urandom);
    drive(1'b1, px, d);
    model_accept(px);
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL pop_edge_dropped got=%b exp=1", bus.overflow); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL pop_edge_busy_fall got=%b exp=0", bus.busy); end
    drive(1'b0, 24'h0, d);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL pop_edge_refill got=%b exp=1", bus.busy); end
    wait_idle(t, ok);
    checks++; if (!ok) begin failures++; $display("FAIL pop_edge_timeout got=0 exp=1"); end
    checks++; if (rx_err != 0) begin failures++; $display("FAIL pop_edge_framing got=%0d exp=0", rx_err); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL pop_edge_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL pop_edge_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_data();
    int n, d, t;
    bit ok;
    logic [23:0] a, c;
    clear_rx();
    a = 24'($urandom) & ~24'h001000;
    drive(1'b1, a, n);
    drive(1'b1, 24'($urandom), d);
    drive(1'b0, 24'h0, d);
    // Middle of data bit 4 of the G byte, which is forced to 0.
    wait_cyc(n + 2 + BYTE_T + 5 * CPB + CPB / 2);
    checks++; if (bus.TxD !== 1'b0) begin failures++; $display("FAIL mid_pre_txd got=%b exp=0", bus.TxD); end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL mid_pre_overflow got=%b exp=1", bus.overflow); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (bus.TxD !== 1'b1) begin failures++; $display("FAIL mid_txd got=%b exp=1", bus.TxD); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.idle !== 1'b1) begin failures++; $display("FAIL mid_idle got=%b exp=1", bus.idle); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL mid_overflow got=%b exp=0", bus.overflow); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_rx();
    repeat (PIX_T + 20) @(negedge clk);
    checks++; if (rx_q.size() != 0 || rx_act) begin failures++; $display("FAIL mid_discard got=%0d exp=0", rx_q.size()); end
    checks++; if (bus.idle !== 1'b1) begin failures++; $display("FAIL mid_idle_after got=%b exp=1", bus.idle); end
    c = 24'($urandom);
    drive(1'b1, c, n);
    model_accept(c);
    drive(1'b0, 24'h0, d);
    wait_idle(t, ok);
    checks++; if (!ok) begin failures++; $display("FAIL mid_timeout got=0 exp=1"); end
    checks++; if (rx_err != 0) begin failures++; $display("FAIL mid_framing got=%0d exp=0", rx_err); end
    checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL mid_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL mid_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
    end
    if (rx_t.size() > 0) begin
      checks++; if (rx_t[0] != n + 2) begin failures++; $display("FAIL mid_restart_latency got=%0d exp=%0d", rx_t[0], n + 2); end
    end
  endtask

  task automatic test_random_bursts();
    int k, d, t;
    bit ok;
    logic [23:0] px;
    for (int it = 0; it < 4; it++) begin
      clear_rx();
      k = $urandom_range(1, 5);
      for (int i = 0; i < k; i++) begin
        px = 24'($urandom);
        drive(1'b1, px, d);
        model_accept(px);
      end
      drive(1'b0, 24'h0, d);
      // From idle the first pixel is popped two edges in, so k pushes leave k-1 queued.
      checks++; if (bus.busy !== (k - 1 >= int'(DEPTH))) begin
        failures++; $display("FAIL rnd%0d_busy got=%b exp=%b", it, bus.busy, (k - 1 >= int'(DEPTH)));
      end
      wait_idle(t, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rnd%0d_timeout got=0 exp=1", it); end
      checks++; if (rx_err != 0) begin failures++; $display("FAIL rnd%0d_framing got=%0d exp=0", it, rx_err); end
      checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, rx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
        checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d_byte%0d got=%h exp=%h", it, i, rx_q[i], exp_q[i]); end
      end
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL rnd%0d_overflow got=%b exp=0", it, bus.overflow); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.rgb   = '0;
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_overflow();
    test_push_on_pop();
    test_reset_mid_data();
    test_random_bursts();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
